// File: rtl/fp16_pkg.sv
// Shared FP16 datapath definitions: field widths, alignment FSM states and
// the unpacked {exponent, mantissa} operand record.
package fp16_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } align_state_t;

  typedef struct packed {
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_operand_t;

endpackage

// File: rtl/mantissa_rshift1_sticky.sv
// One-bit right shift of a {mantissa, guard} word. The bit leaving position 0
// is folded into the running sticky flag.
module mantissa_rshift1_sticky #(
  parameter int W = 12
) (
  input  logic [W-1:0] man_in,
  input  logic         sticky_in,
  output logic [W-1:0] man_out,
  output logic         sticky_out
);

  assign man_out    = {1'b0, man_in[W-1:1]};
  assign sticky_out = sticky_in | man_in[0];

endmodule

// File: rtl/mantissa_align_seq.sv
// Alignment controller for the FP16 adder: orders the operands by exponent and
// right-shifts the smaller mantissa until the exponents match, tracking guard
// and sticky. Define FAST_ALIGN_EN to replace the serial shifter with a
// single-cycle barrel built from the same one-bit stage.
module mantissa_align_seq
  import fp16_pkg::*;
#(
  parameter int EXP_W   = FP16_EXP_W,
  parameter int MAN_W   = FP16_MAN_W,
  parameter int SHIFT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [MAN_W-1:0] man_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man_l,
  output logic [MAN_W:0]   out_man_s,
  output logic             out_sticky,
  output logic             out_swap
);

  // Shifting MAN_W+1 places pushes the whole mantissa through guard; more is pointless.
  localparam int MAX_SHIFT = MAN_W + 1;

  align_state_t         state_reg;
  logic [SHIFT_W-1:0]   cnt_reg;

  logic                 swap_w;
  logic [EXP_W-1:0]     exp_l_w;
  logic [EXP_W-1:0]     exp_s_w;
  logic [MAN_W-1:0]     man_l_w;
  logic [MAN_W-1:0]     man_s_w;
  logic [EXP_W:0]       diff_w;
  logic [SHIFT_W-1:0]   cnt_init_w;
  logic [MAN_W:0]       shift_man_w;
  logic                 shift_sticky_w;

  // Operand ordering; a tie keeps A as the larger operand.
  assign swap_w  = (exp_b > exp_a);
  assign exp_l_w = swap_w ? exp_b : exp_a;
  assign exp_s_w = swap_w ? exp_a : exp_b;
  assign man_l_w = swap_w ? man_b : man_a;
  assign man_s_w = swap_w ? man_a : man_b;
  // One extra bit so the subtraction can never wrap.
  assign diff_w  = {1'b0, exp_l_w} - {1'b0, exp_s_w};

  // Saturate the shift distance at MAN_W+1.
  always_comb begin
    cnt_init_w = SHIFT_W'(diff_w);
    if (int'(diff_w) > MAX_SHIFT) begin
      cnt_init_w = SHIFT_W'(MAX_SHIFT);
    end
  end

  // Serial datapath: one bit per ALIGN cycle on the registered word.
  mantissa_rshift1_sticky #(.W(MAN_W + 1)) u_rshift_serial (
    .man_in     (out_man_s),
    .sticky_in  (out_sticky),
    .man_out    (shift_man_w),
    .sticky_out (shift_sticky_w)
  );

`ifdef FAST_ALIGN_EN
  logic [MAN_W:0] stage_man_w    [0:MAX_SHIFT];
  logic           stage_sticky_w [0:MAX_SHIFT];
  assign stage_man_w[0]    = {man_s_w, 1'b0};
  assign stage_sticky_w[0] = 1'b0;

  // Barrel: stage gi shifts only when the required distance exceeds gi.
  for (genvar gi = 0; gi < MAX_SHIFT; gi++) begin : g_barrel
    logic [MAN_W:0] sh_man;
    logic           sh_sticky;
    mantissa_rshift1_sticky #(.W(MAN_W + 1)) u_stage (
      .man_in     (stage_man_w[gi]),
      .sticky_in  (stage_sticky_w[gi]),
      .man_out    (sh_man),
      .sticky_out (sh_sticky)
    );
    assign stage_man_w[gi+1]    = (gi < int'(cnt_init_w)) ? sh_man    : stage_man_w[gi];
    assign stage_sticky_w[gi+1] = (gi < int'(cnt_init_w)) ? sh_sticky : stage_sticky_w[gi];
  end
`endif

  // Control FSM with registered handshake and data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_exp    <= '0;
      out_man_l  <= '0;
      out_man_s  <= '0;
      out_sticky <= 1'b0;
      out_swap   <= 1'b0;
    end else if (flush) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            out_exp   <= exp_l_w;
            out_man_l <= man_l_w;
            out_swap  <= swap_w;
            in_ready  <= 1'b0;
`ifdef FAST_ALIGN_EN
            out_man_s  <= stage_man_w[MAX_SHIFT];
            out_sticky <= stage_sticky_w[MAX_SHIFT];
            cnt_reg    <= '0;
            state_reg  <= DONE;
            out_valid  <= 1'b1;
`else
            out_man_s  <= {man_s_w, 1'b0};
            out_sticky <= 1'b0;
            cnt_reg    <= cnt_init_w;
            if (cnt_init_w == '0) begin
              state_reg <= DONE;
              out_valid <= 1'b1;
            end else begin
              state_reg <= ALIGN;
            end
`endif
          end
        end
        ALIGN: begin
          out_man_s  <= shift_man_w;
          out_sticky <= shift_sticky_w;
          cnt_reg    <= cnt_reg - 1'b1;
          if (cnt_reg == SHIFT_W'(1)) begin
            state_reg <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_align_seq.sv
// Self-checking bench for mantissa_align_seq: directed cases plus randomized
// operands compared against an arithmetic alignment model.
module tb_mantissa_align_seq;
  import fp16_pkg::*;

  localparam int EW = FP16_EXP_W;
  localparam int MW = FP16_MAN_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] exp_a, exp_b;
  logic [MW-1:0] man_a, man_b;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_man_l;
  logic [MW:0]   out_man_s;
  logic          out_sticky;
  logic          out_swap;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mantissa_align_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .man_a(man_a), .exp_b(exp_b), .man_b(man_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_man_l(out_man_l), .out_man_s(out_man_s),
    .out_sticky(out_sticky), .out_swap(out_swap)
  );

  // Expected result of aligning one operand pair, from plain arithmetic.
  typedef struct {
    int exp; int man_l; int man_s; int sticky; int swap; int cnt;
  } expect_t;

  function automatic expect_t model(input fp16_operand_t a, input fp16_operand_t b);
    expect_t e;
    int d, full;
    e.swap  = (int'(b.exp) > int'(a.exp)) ? 1 : 0;
    e.exp   = e.swap ? int'(b.exp) : int'(a.exp);
    e.man_l = e.swap ? int'(b.man) : int'(a.man);
    full    = 2 * (e.swap ? int'(a.man) : int'(b.man));
    d       = e.swap ? int'(b.exp) - int'(a.exp) : int'(a.exp) - int'(b.exp);
    if (d > MW + 1) d = MW + 1;
    e.cnt    = d;
    e.man_s  = full >> d;
    e.sticky = ((full % (1 << d)) != 0) ? 1 : 0;
    return e;
  endfunction

  function automatic int exp_latency(input int cnt);
`ifdef FAST_ALIGN_EN
    return 1 + 0 * cnt;
`else
    return 1 + cnt;
`endif
  endfunction

  // Presents one operand pair for the accepting edge; returns at the next negedge.
  task automatic send(input fp16_operand_t a, input fp16_operand_t b);
    exp_a = a.exp; man_a = a.man; exp_b = b.exp; man_b = b.man;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; cycles counts from the cycle operands were driven.
  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    fp16_operand_t a, b;
    rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
    exp_a = '0; man_a = '0; exp_b = '0; man_b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_exp !== '0 || out_man_s !== '0) begin
      n_fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b exp=%h man_s=%h required 1 0 0 0",
               in_ready, out_valid, out_exp, out_man_s);
    end
    rst_n = 1'b1;
    @(negedge clk);
    a.exp = 5'd20; a.man = 11'h5A5; b.exp = 5'd12; b.man = 11'h733;
    send(a, b);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_exp !== '0 || out_man_l !== '0 ||
        out_man_s !== '0 || out_sticky !== 1'b0 || out_swap !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid_align: rdy=%b vld=%b exp=%h l=%h s=%h st=%b sw=%b required 1 0 0 0 0 0 0",
               in_ready, out_valid, out_exp, out_man_l, out_man_s, out_sticky, out_swap);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: checked idle state and reset during alignment");
  endtask

  // Runs one op, checks latency and every field, then hands it off.
  task automatic test_op(input string name, input fp16_operand_t a, input fp16_operand_t b,
                         input int stall);
    expect_t e;
    int cyc;
    e = model(a, b);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_in_ready: got %b required 1", name, in_ready);
    end
    out_ready = 1'b0;
    send(a, b);
    wait_valid(cyc);
    n_checks++;
    if (cyc !== exp_latency(e.cnt)) begin
      n_fails++;
      $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc, exp_latency(e.cnt));
    end
    repeat (stall) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_exp) !== e.exp ||
        int'(out_man_l) !== e.man_l || int'(out_man_s) !== e.man_s ||
        int'(out_sticky) !== e.sticky || int'(out_swap) !== e.swap) begin
      n_fails++;
      $display("FAIL %s_result: vld=%b rdy=%b exp=%0d l=%h s=%h st=%b sw=%b required 1 0 %0d %h %h %0d %0d",
               name, out_valid, in_ready, out_exp, out_man_l, out_man_s, out_sticky, out_swap,
               e.exp, e.man_l, e.man_s, e.sticky, e.swap);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_handoff: vld=%b rdy=%b required 0 1", name, out_valid, in_ready);
    end
    $display("op %s: ea=%0d ma=%h eb=%0d mb=%h -> exp=%0d man_s=%h sticky=%0d swap=%0d lat=%0d",
             name, a.exp, a.man, b.exp, b.man, out_exp, out_man_s, out_sticky, out_swap, cyc);
  endtask

  task automatic test_directed();
    fp16_operand_t a, b;
    a.exp = 5'd15; a.man = 11'h400; b.exp = 5'd15; b.man = 11'h600;
    test_op("equal_exp", a, b, 0);
    a.exp = 5'd12; a.man = 11'h7FF; b.exp = 5'd15; b.man = 11'h400;
    test_op("swap_diff3", a, b, 0);
    a.exp = 5'd30; a.man = 11'h400; b.exp = 5'd1; b.man = 11'h401;
    test_op("saturate", a, b, 0);
    a.exp = 5'd9; a.man = 11'h000; b.exp = 5'd2; b.man = 11'h000;
    test_op("zero_man", a, b, 1);
    a.exp = 5'd3; a.man = 11'h4C1; b.exp = 5'd15; b.man = 11'h7FF;
    test_op("diff_exact12", a, b, 0);
  endtask

  task automatic test_backpressure();
    fp16_operand_t a, b;
    expect_t e;
    int cyc;
    a.exp = 5'd10; a.man = 11'h6B3; b.exp = 5'd14; b.man = 11'h5F0;
    e = model(a, b);
    out_ready = 1'b0;
    send(a, b);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_man_s) !== e.man_s ||
          int'(out_sticky) !== e.sticky || int'(out_exp) !== e.exp) begin
        n_fails++;
        $display("FAIL hold_%0d: vld=%b rdy=%b s=%h st=%b exp=%0d required 1 0 %h %0d %0d",
                 i, out_valid, in_ready, out_man_s, out_sticky, out_exp, e.man_s, e.sticky, e.exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL hold_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    $display("backpressure: held result 5 cycles, released to idle");
  endtask

  task automatic test_flush();
    fp16_operand_t a, b, c;
    expect_t e;
    a.exp = 5'd18; a.man = 11'h4F1; b.exp = 5'd10; b.man = 11'h62D;
    c.exp = 5'd4;  c.man = 11'h111;
    e = model(a, b);
    out_ready = 1'b0;
    send(a, b);
    @(negedge clk);
    flush = 1'b1;
    exp_a = c.exp; man_a = c.man; exp_b = 5'd29; man_b = 11'h777; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL flush_align: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || int'(out_exp) !== e.exp || in_ready !== 1'b1) begin
        n_fails++;
        $display("FAIL flush_quiet_%0d: vld=%b exp=%0d rdy=%b required 0 %0d 1",
                 i, out_valid, out_exp, in_ready, e.exp);
      end
      @(negedge clk);
    end
    flush = 1'b1; in_valid = 1'b1; exp_a = 5'd7; exp_b = 5'd7;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || int'(out_exp) !== e.exp) begin
      n_fails++;
      $display("FAIL flush_idle: vld=%b rdy=%b exp=%0d required 0 1 %0d",
               out_valid, in_ready, out_exp, e.exp);
    end
    $display("flush: aborted alignment and dropped operands offered with flush");
  endtask

  task automatic test_back_to_back();
    fp16_operand_t a, b;
    expect_t e;
    int cyc;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a.exp = EW'($urandom_range(0, 31)); a.man = MW'($urandom);
      b.exp = EW'($urandom_range(0, 31)); b.man = MW'($urandom);
      e = model(a, b);
      send(a, b);
      cyc = 1;
      while (!in_ready && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      n_checks++;
      if (cyc !== 1 + exp_latency(e.cnt)) begin
        n_fails++;
        $display("FAIL b2b_%0d_period: got %0d cycles required %0d", k, cyc, 1 + exp_latency(e.cnt));
      end
      n_checks++;
      if (int'(out_man_s) !== e.man_s || int'(out_sticky) !== e.sticky || int'(out_exp) !== e.exp) begin
        n_fails++;
        $display("FAIL b2b_%0d_data: s=%h st=%b exp=%0d required %h %0d %0d",
                 k, out_man_s, out_sticky, out_exp, e.man_s, e.sticky, e.exp);
      end
      $display("b2b %0d: cnt=%0d period=%0d", k, e.cnt, cyc);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    fp16_operand_t a, b;
    string nm;
    for (int k = 0; k < 40; k++) begin
      a.exp = EW'($urandom_range(0, 31));
      b.exp = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 31))
                                           : EW'(int'(a.exp) ^ int'($urandom_range(0, 7)));
      a.man = MW'($urandom) | (($urandom_range(0, 3) != 0) ? 11'h400 : 11'h000);
      b.man = MW'($urandom) | (($urandom_range(0, 3) != 0) ? 11'h400 : 11'h000);
      nm = $sformatf("rand%0d", k);
      test_op(nm, a, b, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
